// File: rtl/syn_fifo_rd_burst_ctrl.sv
// rtl/syn_fifo_rd_burst_ctrl.sv - read-burst controller for syn_fifo with 2-entry skid buffer
// Optional partial-flush timeout enabled by defining FIFO_RD_TIMEOUT_EN.
module syn_fifo_rd_burst_ctrl #(
  parameter int FIFO_ENTRIES = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int BURST_LEN    = 4,
  parameter int TIMEOUT      = 32,
  localparam int LW          = $clog2(FIFO_ENTRIES) + 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  burst_en_i,
  input  logic                  fifo_empty_i,
  input  logic [LW-1:0]         fifo_level_i,
  output logic                  fifo_ren_o,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  input  logic                  m_ready_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {IDLE, BURST, FINISH} state_t;

  localparam logic [LW-1:0] BURST_LW = LW'(BURST_LEN);

  generate
    if (BURST_LEN < 1 || BURST_LEN > FIFO_ENTRIES || TIMEOUT < 1) begin : g_bad_cfg
      $error("syn_fifo_rd_burst_ctrl: illegal BURST_LEN/TIMEOUT");
    end
  endgenerate

  state_t                state, state_n;
  logic [LW-1:0]         beat_cnt, beat_cnt_n;
  logic                  ren;
  logic                  inflight, inflight_last;
  logic [DATA_WIDTH-1:0] skid_data [2];
  logic [1:0]            skid_last;
  logic                  skid_wr, skid_rd;
  logic [1:0]            skid_cnt;
  logic                  push, pop, has_credit, start_full, start_short;

  assign push       = inflight;
  assign pop        = m_valid_o & m_ready_i;
  assign m_valid_o  = (skid_cnt != 2'd0);
  assign m_data_o   = m_valid_o ? skid_data[skid_rd] : '0;
  assign m_last_o   = m_valid_o & skid_last[skid_rd];
  assign busy_o     = (state != IDLE) | m_valid_o;
  assign fifo_ren_o = ren;
  assign start_full = burst_en_i & (fifo_level_i >= BURST_LW);

  // A slot freed by this cycle's pop counts as credit, which sustains one beat per cycle.
  assign has_credit = ({1'b0, skid_cnt} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});

`ifdef FIFO_RD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  logic [TW-1:0] idle_cnt;
  logic          partial;

  assign partial     = burst_en_i & (fifo_level_i != '0) & (fifo_level_i < BURST_LW);
  assign start_short = (state == IDLE) & partial & (idle_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      idle_cnt <= '0;
    end else if (state == IDLE && partial && !start_short) begin
      idle_cnt <= idle_cnt + 1'b1;
    end else begin
      idle_cnt <= '0;
    end
  end
`else
  assign start_short = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    beat_cnt_n = beat_cnt;
    ren        = 1'b0;
    case (state)
      IDLE: begin
        if (start_full) begin
          state_n    = BURST;
          beat_cnt_n = BURST_LW;
        end else if (start_short) begin
          state_n    = BURST;
          beat_cnt_n = fifo_level_i;
        end
      end
      BURST: begin
        ren = ~fifo_empty_i & (beat_cnt != '0) & has_credit;
        if (ren) beat_cnt_n = beat_cnt - 1'b1;
        if (beat_cnt_n == '0) state_n = FINISH;
      end
      FINISH: begin
        if (!m_valid_o && !inflight) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      skid_cnt      <= 2'd0;
      skid_wr       <= 1'b0;
      skid_rd       <= 1'b0;
      skid_last     <= 2'b00;
    end else begin
      state         <= state_n;
      beat_cnt      <= beat_cnt_n;
      inflight      <= ren;
      inflight_last <= ren & (beat_cnt == LW'(1));
      if (push) begin
        skid_last[skid_wr] <= inflight_last;
        skid_wr            <= ~skid_wr;
      end
      if (pop) skid_rd <= ~skid_rd;
      skid_cnt <= skid_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // Payload needs no reset: m_data_o is masked while the buffer is empty.
  always_ff @(posedge sys_clk) begin
    if (push) skid_data[skid_wr] <= fifo_rdata_i;
  end

endmodule
